lab62soc_key_pio: RTL and testbench
===================================

// Module: lab62soc_key_pio
// PURPOSE
//   Avalon-MM slave input PIO; the read-side counterpart of the write-only output PIOs.
//   Samples WIDTH asynchronous board inputs (KEY/SW) into the clk domain.
//   Captures edges per bit and raises a level IRQ to the Nios II.
//   Sits on the lab62soc fabric beside the hex/LED output PIOs; firmware polls it or takes IRQs.
// PARAMETERS
//   WIDTH            4      number of input bits, 1..32
//   EDGE_TYPE        1      0 = rising, 1 = falling, 2 = any edge captured
//   DEBOUNCE_CYCLES  50000  stable cycles required before a bit changes (used only with PIO_IN_DEBOUNCE_EN)
// PORTS
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      word register select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   in_port     in   WIDTH  asynchronous external inputs
//   readdata    out  32     registered read data, zero-extended
//   irq         out  1      level interrupt to CPU
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
//   Reset: readdata = 0, irq = 0; sync stages, debounced value, edge history, irqmask and edgecapture all 0.
//   Sync: in_port passes through 2 flops (s1 -> s2); s2 is "sampled".
//   Filtered value "level": equals sampled, or the debounced value when the feature is compiled in.
//   Register map (word address):
//     0  DATA        R   level, zero-extended; writes ignored
//     1  DIRECTION   R   reads 0; writes ignored
//     2  IRQMASK     RW  bits [WIDTH-1:0]; write loads writedata[WIDTH-1:0]
//     3  EDGECAPTURE R/W1C  write 1 to clear a bit; write 0 leaves it
//   Writes take effect when chipselect && !write_n at the clk edge.
//   Read: readdata <= mux(address) every clk, not gated by chipselect.
//     Data is valid 1 cycle after address; the fabric uses 1 read wait state.
//   Edge detect: prev <= level every cycle. Events:
//     rise = level & ~prev, fall = ~level & prev, any = rise | fall (per EDGE_TYPE).
//   EDGECAPTURE bit: set on event, cleared by W1C.
//     A simultaneous event and clear on the same bit leaves it SET (set wins).
//   irq = |(edgecapture & irqmask), driven from registers with no extra latency.
//   A masked edge is still captured; a later unmask asserts irq on the next cycle.
//   prev resets to 0: an input held high through reset logs a rising edge
//     3 cycles after release (EDGE_TYPE 0/2). Firmware clears EDGECAPTURE at init.
//   Latency: in_port change -> EDGECAPTURE set/irq high = 3 clk (2 sync + 1 capture), no debounce.
//   Unused bits [31:WIDTH] always read 0.
//   Reset mid-operation clears all state immediately; no pending events survive.
// CONFIGURATION
//   PIO_IN_DEBOUNCE_EN defined:
//     per-bit counter of width $clog2(DEBOUNCE_CYCLES+1).
//     Counter clears whenever sampled == level.
//     Otherwise it increments; on reaching DEBOUNCE_CYCLES, level <= sampled and the counter clears.
//     A glitch shorter than DEBOUNCE_CYCLES never reaches level, DATA or EDGECAPTURE.
//   PIO_IN_DEBOUNCE_EN undefined: level = sampled; no counters are synthesised.
// TESTING
//   1 Reset with in_port=4'hF, release; after 4 clk read addr3 -> 0 (EDGE_TYPE 1).
//     Write 4'hF to addr3 -> reads 0.
//   2 in_port 4'hF->4'hE; read addr0 -> 4'hE.
//     addr3 bit0 = 1 three clk after the change; irq stays 0 (mask 0).
//   3 Write addr2=4'h1 with bit0 captured -> irq=1 next clk.
//     Write addr3=4'h1 -> irq=0 next clk; addr3 reads 0.
//   4 A falling edge on bit1 in the same cycle as a W1C of bit1 -> bit1 remains 1 afterwards.
//   5 With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: 5-clk low pulse -> no capture, DATA unchanged.
//     12-clk low -> capture after 2+8+1 clk.
//   6 Assert reset_n low mid-sequence with irq=1 -> irq, readdata, irqmask and edgecapture all 0 at once.

Source files
------------

// File: rtl/lab62soc_key_pio.sv
// Avalon-MM input PIO: synchronises board inputs, captures per-bit edges and raises a level IRQ.
// Optional input debouncing is compiled in with `define PIO_IN_DEBOUNCE_EN.
module lab62soc_key_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clear;
  logic             w_wr_mask;
  logic [31:0]      w_rdmux;
  logic             w_unused_wdata;

  // Upper write-data bits have no register behind them.
  assign w_unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  // A bit only follows the synchroniser after disagreeing for DEBOUNCE_CYCLES straight cycles.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CW-1:0] r_count;
    logic          r_level;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_count <= '0;
        r_level <= 1'b0;
      end else if (r_s2[gi] == r_level) begin
        r_count <= '0;
      end else if (r_count == LAST_COUNT) begin
        r_level <= r_s2[gi];
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end

    assign w_level[gi] = r_level;
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign w_level = r_s2;
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;

  always_comb begin
    w_event = '0;
    case (EDGE_TYPE)
      0:       w_event = w_rise;
      1:       w_event = w_fall;
      default: w_event = w_rise | w_fall;
    endcase
  end

  assign w_wr_mask = chipselect && !write_n && (address == 2'd2);
  assign w_clear   = (chipselect && !write_n && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // New events are OR'd in after the clear so a coincident event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_prev    <= w_level;
      r_edgecap <= (r_edgecap & ~w_clear) | w_event;
      if (w_wr_mask) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (address)
      2'd0:    w_rdmux[WIDTH-1:0] = w_level;
      2'd2:    w_rdmux[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rdmux[WIDTH-1:0] = r_edgecap;
      default: w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdmux;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_lab62soc_key_pio.sv
// Self-checking bench for lab62soc_key_pio (WIDTH=4, falling-edge capture).
// A latency-based model is compared every cycle; literal checks pin the scenarios.
module tb_lab62soc_key_pio;

  localparam int W        = 4;
  localparam int EDGE     = 1;
  localparam int DEB      = 8;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  lab62soc_key_pio #(.WIDTH(W), .EDGE_TYPE(EDGE), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the filtered level is the input as seen two clocks ago (or after the
  // debounce hold time), and an event is logged one clock after the level moves.
  logic [W-1:0] mIn0, mSamp, mLevel, mPrev, mMask, mCap, mEv, mClr;
  logic [31:0]  mRd;
  int           mRun [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mIn0 = '0; mSamp = '0; mLevel = '0; mPrev = '0;
      mMask = '0; mCap = '0; mRd = '0;
      for (int i = 0; i < W; i++) mRun[i] = 0;
    end else begin
      case (EDGE)
        0:       mEv = mLevel & ~mPrev;
        1:       mEv = ~mLevel & mPrev;
        default: mEv = mLevel ^ mPrev;
      endcase
      mRd = 32'd0;
      if (address == 2'd0) mRd[W-1:0] = mLevel;
      if (address == 2'd2) mRd[W-1:0] = mMask;
      if (address == 2'd3) mRd[W-1:0] = mCap;
      mClr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      mCap = (mCap & ~mClr) | mEv;
      if (chipselect && !write_n && address == 2'd2) mMask = writedata[W-1:0];
      mPrev = mLevel;
`ifdef PIO_IN_DEBOUNCE_EN
      for (int i = 0; i < W; i++) begin
        if (mSamp[i] != mLevel[i]) begin
          mRun[i] = mRun[i] + 1;
          if (mRun[i] == DEB) begin
            mLevel[i] = mSamp[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
`else
      mLevel = mIn0;
`endif
      mSamp = mIn0;
      mIn0  = in_port;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    vectors++;
    if (readdata !== mRd) begin
      miscompares++;
      $display("[TB] FAIL model_readdata t=%0t: got %h expected %h", $time, readdata, mRd);
    end
    if (irq !== |(mCap & mMask)) begin
      miscompares++;
      $display("[TB] FAIL model_irq t=%0t: got %b expected %b", $time, irq, |(mCap & mMask));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic applyStimulus(input logic [W-1:0] pattern, input int hold, input logic [1:0] a);
    in_port = pattern;
    address = a;
    repeat (hold) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [W-1:0] pats [8] = '{4'h5, 4'hA, 4'hF, 4'h3, 4'h0, 4'h9, 4'h6, 4'hC};

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in_port = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Held-high input gives a rising edge, which the falling-edge PIO ignores.
    busRead(2'd3, rd); checkOutput("init_edgecap", rd, 32'h0);
    busRead(2'd0, rd); checkOutput("init_data", rd, 32'hF);
    busRead(2'd1, rd); checkOutput("direction_zero", rd, 32'h0);
    busWrite(2'd3, 32'hF);
    busRead(2'd3, rd); checkOutput("w1c_all", rd, 32'h0);

    // Capture latency: three clocks from input change to EDGECAPTURE.
    address = 2'd3; in_port = 4'hE;
    repeat (3) @(negedge clk);
    checkOutput("cap_not_yet", readdata, 32'h0);
    @(negedge clk);
    checkOutput("cap_bit0", readdata, 32'h1);
    checkOutput("masked_irq", {31'd0, irq}, 32'h0);
    busRead(2'd0, rd); checkOutput("data_E", rd, 32'hE);

    busWrite(2'd2, 32'h1);
    checkOutput("unmask_irq", {31'd0, irq}, 32'h1);
    busWrite(2'd3, 32'h1);
    checkOutput("clear_irq", {31'd0, irq}, 32'h0);
    busRead(2'd3, rd); checkOutput("cleared_cap", rd, 32'h0);

    // Falling edge on bit1 lands on the same clock as its W1C.
    in_port = 4'hC; address = 2'd0;
    repeat (2) @(negedge clk);
    busWrite(2'd3, 32'h2);
    busRead(2'd3, rd); checkOutput("set_wins", rd, 32'h2);
    checkOutput("bit1_masked", {31'd0, irq}, 32'h0);
    busWrite(2'd2, 32'h2);
    checkOutput("late_unmask", {31'd0, irq}, 32'h1);

`ifdef PIO_IN_DEBOUNCE_EN
    applyStimulus(4'h4, 5, 2'd0);
    applyStimulus(4'hC, 20, 2'd0);
    busRead(2'd0, rd); checkOutput("glitch_data", rd, 32'hC);
    busRead(2'd3, rd); checkOutput("glitch_cap", rd, 32'h2);
    address = 2'd3; in_port = 4'h4;
    repeat (11) @(negedge clk);
    checkOutput("deb_not_yet", readdata, 32'h2);
    @(negedge clk);
    checkOutput("deb_capture", readdata, 32'hA);
    applyStimulus(4'hC, 15, 2'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      applyStimulus(pats[i], 3 + (i % 3), 2'(i));
      if (i % 3 == 2) busWrite(2'd3, 32'hF);
    end
    applyStimulus(4'hC, 15, 2'd0);
    busWrite(2'd3, 32'hF);
    busWrite(2'd2, 32'hF);
    busRead(2'd3, rd); checkOutput("pre_fall_cap", rd, 32'h0);

    applyStimulus(4'h0, 14, 2'd0);
    checkOutput("irq_before_reset", {31'd0, irq}, 32'h1);
    busRead(2'd3, rd); checkOutput("fall_cap_C", rd, 32'hC);

    // Asynchronous reset in the middle of a clock phase.
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_irq", {31'd0, irq}, 32'h0);
    checkOutput("async_rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    busRead(2'd2, rd); checkOutput("rst_mask", rd, 32'h0);
    busRead(2'd3, rd); checkOutput("rst_cap", rd, 32'h0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
